// File: rtl/multicycle_control_fsm.sv
// Multi-cycle LEGv8 control sequencer: one shared memory port, FETCH/DECODE/EXEC/MEM/WB
// states, retired-instruction counter, and sticky halts on illegal opcodes or memory timeout.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             PCSrc,
    output logic             unconditional_branch,
    output logic             Reg2Loc,
    output logic             ALUSrc,
    output logic [1:0]       ALUOp,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_NONE = 3'd0,
        C_R    = 3'd1,
        C_LDUR = 3'd2,
        C_STUR = 3'd3,
        C_CBZ  = 3'd4,
        C_B    = 3'd5
    } class_t;

    // The wait counter only needs to reach MEM_TIMEOUT; with the timeout disabled it may wrap freely.
    localparam int                WAIT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam bit                TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_t             state_q, state_d;
    class_t             class_q, class_d;
    class_t             decClass;
    logic [WAIT_W-1:0]  waitCnt_q, waitCnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;
    logic               retire;
    logic               expired;

    always_comb begin
        decClass = C_NONE;
        casez (opcode)
            11'b11111000010: decClass = C_LDUR;
            11'b11111000000: decClass = C_STUR;
            11'b10110100???: decClass = C_CBZ;
            11'b000101?????: decClass = C_B;
            11'b1??0101?000: decClass = C_R;
            default:         decClass = C_NONE;
        endcase
    end

    always_comb begin
        state_d              = state_q;
        class_d              = class_q;
        count_d              = count_q;
        illegal_d            = illegal_q;
        timeout_d            = timeout_q;
        waitCnt_d            = waitCnt_q;
        retire               = 1'b0;
        pc_write             = 1'b0;
        ir_write             = 1'b0;
        PCSrc                = 1'b0;
        unconditional_branch = 1'b0;
        Reg2Loc              = 1'b0;
        ALUSrc               = 1'b0;
        ALUOp                = 2'b00;
        MemRead              = 1'b0;
        MemWrite             = 1'b0;
        MemtoReg             = 1'b0;
        RegWrite             = 1'b0;
        expired              = TIMEOUT_EN && !mem_ready && (waitCnt_q == WAIT_LIMIT);

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (expired) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end
            end
            S_DECODE: begin
                Reg2Loc = (decClass == C_STUR) || (decClass == C_CBZ);
                class_d = decClass;
                case (decClass)
                    C_NONE: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                    C_B: begin
                        pc_write             = 1'b1;
                        PCSrc                = 1'b1;
                        unconditional_branch = 1'b1;
                        retire               = 1'b1;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (class_q)
                    C_R: begin
                        ALUOp   = 2'b10;
                        state_d = S_WB;
                    end
                    C_LDUR, C_STUR: begin
                        ALUSrc  = 1'b1;
                        state_d = S_MEM;
                    end
                    C_CBZ: begin
                        Reg2Loc  = 1'b1;
                        ALUOp    = 2'b01;
                        pc_write = zero;
                        PCSrc    = zero;
                        retire   = 1'b1;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                // Strobes stay asserted for every stall cycle so the access is never dropped.
                if (class_q == C_LDUR) begin
                    MemRead = 1'b1;
                    ALUSrc  = 1'b1;
                end else begin
                    MemWrite = 1'b1;
                    Reg2Loc  = 1'b1;
                end
                if (mem_ready) begin
                    if (class_q == C_LDUR) state_d = S_WB;
                    else                   retire  = 1'b1;
                end else if (expired) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemtoReg = (class_q == C_LDUR);
                retire   = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase

        if (retire) begin
            count_d = count_q + CNT_W'(1);
            state_d = run ? S_FETCH : S_IDLE;
        end

        if (state_d != state_q)
            waitCnt_d = '0;
        else if (((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready)
            waitCnt_d = waitCnt_q + WAIT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            class_q   <= C_NONE;
            waitCnt_q <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            waitCnt_q <= waitCnt_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign state       = state_q;
    assign illegal     = illegal_q;
    assign timeout     = timeout_q;
    assign instr_count = count_q;

endmodule
